// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and default constants for the pipeline stall controller.
package pipeline_stall_controller_pkg;

  // Controller FSM: normal flow or waiting on the SRAM controller
  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } stall_state_t;

  localparam int DEF_MEM_TIMEOUT      = 64;
  localparam int DEF_MAX_HAZARD_STALL = 2;
  localparam int DEF_STAT_W           = 32;

  // Bits needed to hold values 0..max
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the stall watchdogs.
import pipeline_stall_controller_pkg::*;

module sat_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  assign at_max = (count == MAX_V);

  // Count up on inc, stick at MAX, clear wins over inc
  always_ff @(posedge clk) begin
    if (rst || clr)          count <= '0;
    else if (inc && !at_max) count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush arbitration for a 5-stage pipeline.
// Priority: memory wait > taken-branch flush > data-hazard bubble.
// Optional statistics counters are built when STALL_STATS_EN is defined;
// otherwise stall_cycles/flush_events are tied to zero.
import pipeline_stall_controller_pkg::*;

module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT      = DEF_MEM_TIMEOUT,
  parameter int MAX_HAZARD_STALL = DEF_MAX_HAZARD_STALL,
  parameter int STAT_W           = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              freeze_pc,
  output logic              freeze_if_id,
  output logic              freeze_id_exe,
  output logic              freeze_exe_mem,
  output logic              flush_if_id,
  output logic              flush_id_exe,
  output logic              mem_timeout_err,
  output logic              hazard_err,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_events
);

  localparam int MEM_W = cnt_w(MEM_TIMEOUT);
  localparam int HAZ_MAX = MAX_HAZARD_STALL + 1;
  localparam int HAZ_W = cnt_w(HAZ_MAX);

  stall_state_t state, state_next;
  logic             mem_stall;
  logic             mem_inc, mem_clr, mem_at_max, mem_hit;
  logic             haz_inc, haz_clr, haz_at_max, haz_hit;
  logic [MEM_W-1:0] mem_cnt;
  logic [HAZ_W-1:0] haz_cnt;

  // An access still in flight; mem_ready alone (no request) means nothing
  assign mem_stall = mem_req && !mem_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  // Next state and same-cycle freeze/flush arbitration
  always_comb begin
    state_next     = state;
    freeze_pc      = 1'b0;
    freeze_if_id   = 1'b0;
    freeze_id_exe  = 1'b0;
    freeze_exe_mem = 1'b0;
    flush_if_id    = 1'b0;
    flush_id_exe   = 1'b0;
    haz_inc        = 1'b0;
    case (state)
      ST_RUN:      if (mem_stall)  state_next = ST_MEM_WAIT;
      ST_MEM_WAIT: if (!mem_stall) state_next = ST_RUN;
      default:     state_next = ST_RUN;
    endcase
    if (!rst) begin
      if (mem_stall) begin
        // Whole front end holds; branch/hazard stay latched in the frozen stages
        freeze_pc      = 1'b1;
        freeze_if_id   = 1'b1;
        freeze_id_exe  = 1'b1;
        freeze_exe_mem = 1'b1;
      end else if (branch_taken) begin
        // Wrong-path instrs squashed; any dependent hazard goes with them
        flush_if_id  = 1'b1;
        flush_id_exe = 1'b1;
      end else if (hazard) begin
        // Hold fetch/decode and push a bubble into EXE
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
        flush_id_exe = 1'b1;
        haz_inc      = 1'b1;
      end
    end
  end

  // Mem watchdog: counts not-ready cycles spent in MEM_WAIT
  assign mem_inc = (state == ST_MEM_WAIT) && mem_stall;
  assign mem_clr = !mem_inc;
  assign mem_hit = mem_inc && (int'(mem_cnt) == MEM_TIMEOUT - 1);

  // Hazard watchdog: a mem stall neither advances nor clears the run
  assign haz_clr = !mem_stall && !haz_inc;
  assign haz_hit = haz_inc && (int'(haz_cnt) == MAX_HAZARD_STALL);

  sat_counter #(.WIDTH(MEM_W), .MAX(MEM_TIMEOUT)) u_mem_cnt (
    .clk(clk), .rst(rst), .inc(mem_inc), .clr(mem_clr),
    .count(mem_cnt), .at_max(mem_at_max)
  );

  sat_counter #(.WIDTH(HAZ_W), .MAX(HAZ_MAX)) u_haz_cnt (
    .clk(clk), .rst(rst), .inc(haz_inc), .clr(haz_clr),
    .count(haz_cnt), .at_max(haz_at_max)
  );

  // Sticky error flags, set on the edge the watchdog limit is reached
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_timeout_err <= 1'b0;
      hazard_err      <= 1'b0;
    end else begin
      mem_timeout_err <= mem_timeout_err | mem_hit | mem_at_max;
      hazard_err      <= hazard_err | haz_hit | haz_at_max;
    end
  end

`ifdef STALL_STATS_EN
  // Free-running wrap-around statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (freeze_pc)   stall_cycles <= stall_cycles + 1'b1;
      if (flush_if_id) flush_events <= flush_events + 1'b1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule
